// File: rtl/alu_result_checker.sv
// ALU result checker: replays vectors against a 2-stage expected-value
// pipeline and keeps pass/fail counts plus the index of the first miss.
module alu_result_checker #(
  parameter int N     = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [1:0]       vec_f,
  input  logic [N-1:0]     vec_a,
  input  logic [N-1:0]     vec_b,
  input  logic [N-1:0]     dut_s,
  input  logic             dut_co,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic             first_fail_vld,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ALL1 = '1;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_num;
  logic [CNT_W-1:0] r_idx;

  logic             r_s1_v;
  logic [1:0]       r_s1_f;
  logic [N-1:0]     r_s1_a;
  logic [N-1:0]     r_s1_b;
  logic [N-1:0]     r_s1_s;
  logic             r_s1_co;
  logic [CNT_W-1:0] r_s1_idx;

  logic             r_s2_v;
  logic             r_s2_mis;
  logic [CNT_W-1:0] r_s2_idx;

  logic             r_ffv;
  logic [CNT_W-1:0] r_ffi;
  logic [CNT_W-1:0] r_pass;
  logic [CNT_W-1:0] r_fail;

  logic             w_acc;
  logic             w_start;
  logic             w_last;
  logic             w_mis;
  logic [N:0]       w_exp;

  assign w_acc   = vec_valid && (r_state == S_RUN);
  assign w_start = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last  = w_acc && (r_idx == (r_num - ONE));

  assign vec_ready      = (r_state == S_RUN);
  assign busy           = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done           = (r_state == S_DONE);
  assign pass_cnt       = r_pass;
  assign fail_cnt       = r_fail;
  assign first_fail_idx = r_ffi;
  assign first_fail_vld = r_ffv;

  // Run control: sample num_vec on start, count beats, drain the pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_num   <= '0;
      r_idx   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_num   <= num_vec;
            r_idx   <= '0;
            r_state <= (num_vec == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (w_acc) begin
            r_idx <= r_idx + ONE;
            if (w_last) r_state <= S_DRAIN;
          end
        end
        default: begin
          if (r_s2_v && !r_s1_v) r_state <= S_DONE;
        end
      endcase
    end
  end

  // Stage 1: capture the accepted beat and its index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v   <= 1'b0;
      r_s1_f   <= '0;
      r_s1_a   <= '0;
      r_s1_b   <= '0;
      r_s1_s   <= '0;
      r_s1_co  <= 1'b0;
      r_s1_idx <= '0;
    end else begin
      r_s1_v <= w_acc;
      if (w_acc) begin
        r_s1_f   <= vec_f;
        r_s1_a   <= vec_a;
        r_s1_b   <= vec_b;
        r_s1_s   <= dut_s;
        r_s1_co  <= dut_co;
        r_s1_idx <= r_idx;
      end
    end
  end

  // Expected {co,s}; subtract carries out 1 when there is no borrow.
  always_comb begin
    w_exp = '0;
    unique case (r_s1_f)
      2'b00:   w_exp = {1'b0, r_s1_a} + {1'b0, r_s1_b};
      2'b01:   w_exp = {1'b0, r_s1_a} + {1'b0, ~r_s1_b}
                       + {{N{1'b0}}, 1'b1};
      2'b10:   w_exp = {1'b0, r_s1_a & r_s1_b};
      default: w_exp = {1'b0, r_s1_a | r_s1_b};
    endcase
  end

  assign w_mis = (w_exp != {r_s1_co, r_s1_s});

  // Stage 2: register the compare result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_v   <= 1'b0;
      r_s2_mis <= 1'b0;
      r_s2_idx <= '0;
    end else begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_s2_mis <= w_mis;
        r_s2_idx <= r_s1_idx;
      end
    end
  end

  // Result counters saturate; only the first miss of a run is recorded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pass <= '0;
      r_fail <= '0;
      r_ffv  <= 1'b0;
      r_ffi  <= '0;
    end else if (w_start) begin
      r_pass <= '0;
      r_fail <= '0;
      r_ffv  <= 1'b0;
      r_ffi  <= '0;
    end else if (r_s2_v) begin
      if (r_s2_mis) begin
        if (r_fail != ALL1) r_fail <= r_fail + ONE;
        if (!r_ffv) begin
          r_ffv <= 1'b1;
          r_ffi <= r_s2_idx;
        end
      end else if (r_pass != ALL1) begin
        r_pass <= r_pass + ONE;
      end
    end
  end

endmodule
